// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_unit
// Brief    : Captures ALU results, derives ZERO/NEG/CARRY/OVF, and commits
//            them under a per-flag write mask into the architectural flag
//            register. Also keeps a sticky overflow bit and a commit strobe.
// Revision : 1.0 - initial release
// ============================================================================
module flag_unit #(
    parameter int DATA_WIDTH   = 16,
    parameter int FLAGS_LENGTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    STALL,
    input  logic                    ALU_VALID,
    input  logic [DATA_WIDTH-1:0]   ALU_RESULT,
    input  logic                    ALU_COUT,
    input  logic                    OPA_MSB,
    input  logic                    OPB_MSB,
    input  logic [FLAGS_LENGTH-1:0] FLAG_WE,
    input  logic                    CLR_STICKY,
    output logic [FLAGS_LENGTH-1:0] ALU_FLAGS,
    output logic                    STICKY_OVF,
    output logic                    FLAGS_VALID
);

    // Fixed flag bit map
    localparam int c_ZERO_BIT  = 0;
    localparam int c_NEG_BIT   = 1;
    localparam int c_CARRY_BIT = 2;
    localparam int c_OVF_BIT   = 3;

    // S1 capture registers
    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_result;
    logic                    r_s1_cout;
    logic                    r_s1_opa_msb;
    logic                    r_s1_opb_msb;
    logic [FLAGS_LENGTH-1:0] r_s1_we;

    // S2 combinational results
    logic [FLAGS_LENGTH-1:0] w_new_flags;
    logic                    w_commit;
    logic                    w_sticky_set;

    // S1 valid bit: advances whenever the pipe is not frozen
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_valid <= 1'b0;
        end else if (!STALL) begin
            r_s1_valid <= ALU_VALID;
        end
    end

    // S1 payload: only loaded for a valid, unstalled ALU result
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_result  <= '0;
            r_s1_cout    <= 1'b0;
            r_s1_opa_msb <= 1'b0;
            r_s1_opb_msb <= 1'b0;
            r_s1_we      <= '0;
        end else if (!STALL && ALU_VALID) begin
            r_s1_result  <= ALU_RESULT;
            r_s1_cout    <= ALU_COUT;
            r_s1_opa_msb <= OPA_MSB;
            r_s1_opb_msb <= OPB_MSB;
            r_s1_we      <= FLAG_WE;
        end
    end

    // Flag derivation from the captured result; signed overflow means both
    // operands share a sign that the result does not
    always_comb begin
        w_new_flags              = '0;
        w_new_flags[c_ZERO_BIT]  = (r_s1_result == '0);
        w_new_flags[c_NEG_BIT]   = r_s1_result[DATA_WIDTH-1];
        w_new_flags[c_CARRY_BIT] = r_s1_cout;
        w_new_flags[c_OVF_BIT]   = (r_s1_opa_msb == r_s1_opb_msb) &&
                                   (r_s1_result[DATA_WIDTH-1] != r_s1_opa_msb);
        w_commit                 = r_s1_valid && !STALL;
        w_sticky_set             = w_commit && r_s1_we[c_OVF_BIT] &&
                                   w_new_flags[c_OVF_BIT];
    end

    // Architectural flags: masked merge on commit, hold otherwise
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ALU_FLAGS <= '0;
        end else if (w_commit) begin
            ALU_FLAGS <= (ALU_FLAGS & ~r_s1_we) | (w_new_flags & r_s1_we);
        end
    end

    // Commit strobe: follows S1 valid, frozen (not cleared) during a stall
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FLAGS_VALID <= 1'b0;
        end else if (!STALL) begin
            FLAGS_VALID <= r_s1_valid;
        end
    end

    // Sticky overflow: a committed overflow beats a same-cycle clear
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            STICKY_OVF <= 1'b0;
        end else if (w_sticky_set) begin
            STICKY_OVF <= 1'b1;
        end else if (CLR_STICKY) begin
            STICKY_OVF <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_unit
// Brief    : Self-checking bench for flag_unit with an in-order scoreboard of
//            expected committed flag values plus directed timing checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flag_unit;

    logic        CLK;
    logic        RST_N;
    logic        STALL;
    logic        ALU_VALID;
    logic [15:0] ALU_RESULT;
    logic        ALU_COUT;
    logic        OPA_MSB;
    logic        OPB_MSB;
    logic [3:0]  FLAG_WE;
    logic        CLR_STICKY;
    logic [3:0]  ALU_FLAGS;
    logic        STICKY_OVF;
    logic        FLAGS_VALID;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  sb_q[$];
    logic [3:0]  model_flags = 4'b0000;
    logic        edge_stalled = 1'b0;

    flag_unit #(
        .DATA_WIDTH   (16),
        .FLAGS_LENGTH (4)
    ) u_dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .STALL       (STALL),
        .ALU_VALID   (ALU_VALID),
        .ALU_RESULT  (ALU_RESULT),
        .ALU_COUT    (ALU_COUT),
        .OPA_MSB     (OPA_MSB),
        .OPB_MSB     (OPB_MSB),
        .FLAG_WE     (FLAG_WE),
        .CLR_STICKY  (CLR_STICKY),
        .ALU_FLAGS   (ALU_FLAGS),
        .STICKY_OVF  (STICKY_OVF),
        .FLAGS_VALID (FLAGS_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Remember whether the most recent edge was a stalled one
    always @(posedge CLK) edge_stalled <= STALL;

    // Scoreboard consumer: every fresh commit must match the oldest expectation
    always @(negedge CLK) begin
        if (RST_N && FLAGS_VALID && !edge_stalled) begin
            check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) check("sb_flags", 32'(ALU_FLAGS), 32'(sb_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Drive one valid ALU result and push its expected committed flags
    task automatic send(input logic [15:0] res, input logic cout, input logic a,
                        input logic b, input logic [3:0] we);
        logic [3:0] nf;
        nf[0] = (res == 16'h0000);
        nf[1] = res[15];
        nf[2] = cout;
        nf[3] = (a == b) && (res[15] != a);
        model_flags = (model_flags & ~we) | (nf & we);
        sb_q.push_back(model_flags);
        ALU_VALID  = 1'b1;
        ALU_RESULT = res;
        ALU_COUT   = cout;
        OPA_MSB    = a;
        OPB_MSB    = b;
        FLAG_WE    = we;
        tick();
        ALU_VALID  = 1'b0;
    endtask

    task automatic idle();
        ALU_VALID = 1'b0;
        tick();
    endtask

    initial begin
        RST_N = 1'b0; STALL = 1'b0; ALU_VALID = 1'b0; ALU_RESULT = '0;
        ALU_COUT = 1'b0; OPA_MSB = 1'b0; OPB_MSB = 1'b0; FLAG_WE = '0;
        CLR_STICKY = 1'b0;
        tick(); tick();
        check("rst_flags", 32'(ALU_FLAGS), 32'h0);
        check("rst_valid", 32'(FLAGS_VALID), 32'h0);
        check("rst_sticky", 32'(STICKY_OVF), 32'h0);
        RST_N = 1'b1;
        idle();
        check("post_rst_valid", 32'(FLAGS_VALID), 32'h0);

        // Zero result: two edges later, ZERO set and a single-cycle strobe
        send(16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111);
        check("zero_lat_valid_lo", 32'(FLAGS_VALID), 32'h0);
        idle();
        check("zero_flags", 32'(ALU_FLAGS), 32'h1);
        check("zero_valid_hi", 32'(FLAGS_VALID), 32'h1);
        idle();
        check("zero_valid_pulse", 32'(FLAGS_VALID), 32'h0);

        // Signed overflow and sticky behaviour
        send(16'h8000, 1'b0, 1'b0, 1'b0, 4'b1111);
        idle();
        check("ovf_flags", 32'(ALU_FLAGS), 32'hA);
        check("ovf_sticky", 32'(STICKY_OVF), 32'h1);
        send(16'h0001, 1'b0, 1'b0, 1'b0, 4'b1111);
        idle();
        check("noovf_flags", 32'(ALU_FLAGS), 32'h0);
        check("sticky_held", 32'(STICKY_OVF), 32'h1);
        CLR_STICKY = 1'b1;
        idle();
        CLR_STICKY = 1'b0;
        check("sticky_clr", 32'(STICKY_OVF), 32'h0);

        // Overflow commit coinciding with a clear: set wins
        send(16'h8000, 1'b0, 1'b0, 1'b0, 4'b1000);
        CLR_STICKY = 1'b1;
        idle();
        CLR_STICKY = 1'b0;
        check("sticky_set_wins", 32'(STICKY_OVF), 32'h1);
        CLR_STICKY = 1'b1;
        idle();
        CLR_STICKY = 1'b0;

        // Partial mask: only NEG updated
        send(16'h0000, 1'b1, 1'b0, 1'b0, 4'b1111);
        idle();
        check("mask_pre", 32'(ALU_FLAGS), 32'h5);
        send(16'hFFFF, 1'b0, 1'b1, 1'b1, 4'b0010);
        idle();
        check("mask_neg_only", 32'(ALU_FLAGS), 32'h7);
        send(16'h1234, 1'b1, 1'b0, 1'b0, 4'b0000);
        check("we0_valid_lo", 32'(FLAGS_VALID), 32'h0);
        idle();
        check("we0_valid_hi", 32'(FLAGS_VALID), 32'h1);
        check("we0_flags_held", 32'(ALU_FLAGS), 32'h7);

        // Back-to-back results
        send(16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111);
        send(16'h8000, 1'b0, 1'b1, 1'b0, 4'b1111);
        check("b2b_v1", 32'(FLAGS_VALID), 32'h1);
        check("b2b_f1", 32'(ALU_FLAGS), 32'h1);
        send(16'h0005, 1'b0, 1'b0, 1'b0, 4'b1111);
        check("b2b_v2", 32'(FLAGS_VALID), 32'h1);
        check("b2b_f2", 32'(ALU_FLAGS), 32'h2);
        idle();
        check("b2b_v3", 32'(FLAGS_VALID), 32'h1);
        check("b2b_f3", 32'(ALU_FLAGS), 32'h0);
        idle();
        check("b2b_end", 32'(FLAGS_VALID), 32'h0);

        // Stall of 3 cycles with a result pending; stall-time inputs ignored
        send(16'h7FFF, 1'b1, 1'b0, 1'b0, 4'b1111);
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ALU_VALID = 1'b1; ALU_RESULT = 16'h0000; FLAG_WE = 4'b1111;
            tick();
            check("stall_flags", 32'(ALU_FLAGS), 32'h0);
            check("stall_valid", 32'(FLAGS_VALID), 32'h0);
        end
        STALL = 1'b0;
        idle();
        check("stall_commit_flags", 32'(ALU_FLAGS), 32'h4);
        check("stall_commit_valid", 32'(FLAGS_VALID), 32'h1);
        idle();
        check("stall_after", 32'(FLAGS_VALID), 32'h0);

        // Stall while the strobe is high: it stays frozen high
        send(16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111);
        send(16'h8000, 1'b1, 1'b1, 1'b1, 4'b1111);
        STALL = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_hi_valid", 32'(FLAGS_VALID), 32'h1);
            check("stall_hi_flags", 32'(ALU_FLAGS), 32'h1);
        end
        STALL = 1'b0;
        idle();
        check("stall_hi_commit", 32'(ALU_FLAGS), 32'h6);
        idle();

        // Asynchronous reset mid-stream with S1 occupied
        send(16'h8000, 1'b1, 1'b0, 1'b0, 4'b1111);
        send(16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111);
        check("pre_rst_sticky", 32'(STICKY_OVF), 32'h1);
        RST_N = 1'b0;
        sb_q.delete();
        model_flags = 4'b0000;
        #1;
        check("async_rst_flags", 32'(ALU_FLAGS), 32'h0);
        check("async_rst_valid", 32'(FLAGS_VALID), 32'h0);
        check("async_rst_sticky", 32'(STICKY_OVF), 32'h0);
        tick();
        RST_N = 1'b1;
        idle();
        check("rel_valid", 32'(FLAGS_VALID), 32'h0);
        idle();
        check("rel_valid2", 32'(FLAGS_VALID), 32'h0);
        check("rel_flags", 32'(ALU_FLAGS), 32'h0);

        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
